two_channel_demux: RTL

Two-channel demultiplexer for the receive end of a time-shared single-wire link driven by our two-channel mux. One input stream is routed to one of two registered output channels, chosen either by an external select or by an internal round-robin slot sequencer that locks to a frame-sync strobe. Sits between the shared link input pins and the per-channel consumer logic on the iCEstick.

---
 rtl/two_channel_demux.sv | 122 ++++++++++++
 1 files changed

// File: rtl/two_channel_demux.sv
// Receive-side demux for the time-shared two-channel link: routes each valid sample to one of
// two registered channels. Optional per-channel sample counters are enabled by TWO_CHANNEL_DEMUX_COUNT_EN.
module two_channel_demux #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clock_input,
  input  logic                  reset_input,
  input  logic [DATA_WIDTH-1:0] demux_in,
  input  logic                  demux_in_valid,
  input  logic                  frame_sync,
  input  logic                  auto_mode,
  input  logic                  selection_input,
  output logic [DATA_WIDTH-1:0] output_channel_1,
  output logic [DATA_WIDTH-1:0] output_channel_2,
  output logic                  output_valid_1,
  output logic                  output_valid_2,
  output logic                  locked,
  output logic                  frame_error,
  output logic [7:0]            sample_count_1,
  output logic [7:0]            sample_count_2
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SLOT_1    = 2'd1,
    SLOT_2    = 2'd2
  } seq_state_e;

  seq_state_e            state_q, state_d, cur_state;
  logic                  auto_q;
  logic [DATA_WIDTH-1:0] ch1_q, ch2_q;
  logic                  valid1_q, valid2_q, locked_q, err_q;
  logic                  route1_d, route2_d, err_d;

  // Any auto_mode edge, or manual mode itself, makes the sequencer start from WAIT_SYNC.
  assign cur_state = (auto_mode && auto_q) ? state_q : WAIT_SYNC;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = cur_state;
    route1_d = 1'b0;
    route2_d = 1'b0;
    err_d    = 1'b0;
    if (!auto_mode) begin
      state_d  = WAIT_SYNC;
      route1_d = demux_in_valid &&  selection_input;
      route2_d = demux_in_valid && !selection_input;
    end else if (demux_in_valid) begin
      unique case (cur_state)
        WAIT_SYNC: if (frame_sync) begin
          route1_d = 1'b1;
          state_d  = SLOT_2;
        end
        SLOT_2: if (frame_sync) begin
          // Sync in the channel-2 slot: report it and realign on this sample.
          err_d    = 1'b1;
          route1_d = 1'b1;
        end else begin
          route2_d = 1'b1;
          state_d  = SLOT_1;
        end
        SLOT_1: begin
          route1_d = 1'b1;
          state_d  = SLOT_2;
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock_input) begin
    if (reset_input) begin
      state_q  <= WAIT_SYNC;
      auto_q   <= 1'b0;
      ch1_q    <= '0;
      ch2_q    <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      auto_q   <= auto_mode;
      valid1_q <= route1_d;
      valid2_q <= route2_d;
      locked_q <= (state_d != WAIT_SYNC);
      err_q    <= err_d;
      if (route1_d) ch1_q <= demux_in;
      if (route2_d) ch2_q <= demux_in;
    end
  end

  assign output_channel_1 = ch1_q;
  assign output_channel_2 = ch2_q;
  assign output_valid_1   = valid1_q;
  assign output_valid_2   = valid2_q;
  assign locked           = locked_q;
  assign frame_error      = err_q;

`ifdef TWO_CHANNEL_DEMUX_COUNT_EN
  logic [7:0] cnt1_q, cnt2_q;

  // Counters advance with the strobe they count, so both become visible in the same cycle.
  always_ff @(posedge clock_input) begin
    if (reset_input) begin
      cnt1_q <= 8'd0;
      cnt2_q <= 8'd0;
    end else begin
      if (route1_d && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
      if (route2_d && (cnt2_q != 8'hFF)) cnt2_q <= cnt2_q + 8'd1;
    end
  end

  assign sample_count_1 = cnt1_q;
  assign sample_count_2 = cnt2_q;
`else
  assign sample_count_1 = 8'd0;
  assign sample_count_2 = 8'd0;
`endif

endmodule
